// File: rtl/ds3502_wr_sched.sv
// ds3502_wr_sched: round-robin scheduler sharing one ds3502 I2C write engine between N_REQ
// requesters. A granted request's register address and value are latched and held on
// eng_addr/eng_val. The block pulses eng_load, then follows eng_busy through the transfer and
// returns a one-cycle done (with err) to the requester it served. If busy never rises within
// START_CYC, or stays high past TIMEOUT_CYC, the engine is held in reset for RST_CYC cycles and
// the transaction is reported with err=1.
//
// Optional feature: define DS3502_INIT_EN to write (0x02, INIT_CR) and then (0x00, INIT_WR)
// after reset, before any request is accepted. No done pulse is issued for these writes.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req                 level request per requester, held until its done pulse
//   req_addr, req_val   8-bit address/value per requester, slice [8i+7:8i]
//   done, err           one-cycle per-requester completion; err is valid only with done
//   eng_load            one-cycle load pulse to the engine
//   eng_addr, eng_val   register address/value to the engine, held through the transfer
//   eng_busy            engine busy
//   eng_rst_n           engine reset (active-low), low during reset and recovery
//   init_done           high once the block accepts requests
module ds3502_wr_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned START_CYC   = 4,
  parameter int unsigned RST_CYC     = 16,
  parameter logic [7:0]  INIT_CR     = 8'h80,
  parameter logic [7:0]  INIT_WR     = 8'h40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_val,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               eng_load,
  output logic [7:0]         eng_addr,
  output logic [7:0]         eng_val,
  input  logic               eng_busy,
  output logic               eng_rst_n,
  output logic               init_done
);

  localparam int unsigned GW = $clog2(N_REQ);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RECOVER   = 3'd4;
  localparam logic [2:0] REPORT    = 3'd5;
`ifdef DS3502_INIT_EN
  localparam logic [2:0] INIT0     = 3'd6;
  localparam logic [2:0] INIT1     = 3'd7;
  localparam logic [2:0] RST_STATE = INIT0;
`else
  localparam logic [2:0] RST_STATE = IDLE;
`endif

  logic [2:0]    state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    val_q, val_d;
  logic          rst_n_q;
  logic          init_done_q, init_done_d;
  logic          in_init;

`ifdef DS3502_INIT_EN
  logic init_ph_q, init_ph_d;   // current transaction is an init write
  logic init_sel_q, init_sel_d; // 0: control register write, 1: wiper write
  assign in_init = init_ph_q;
`else
  logic unused_init;
  assign unused_init = ^{INIT_CR, INIT_WR};
  assign in_init     = 1'b0;
`endif

  // Round-robin pick: lowest requesting index at or above ptr_q, wrapping.
  logic          found;
  logic [GW-1:0] pick;
  int unsigned   idx;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '1) ? cnt_q + 20'd1 : cnt_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    addr_d      = addr_q;
    val_d       = val_q;
`ifdef DS3502_INIT_EN
    init_done_d = init_done_q;
    init_ph_d   = init_ph_q;
    init_sel_d  = init_sel_q;
`else
    init_done_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          addr_d  = req_addr[8*int'(pick) +: 8];
          val_d   = req_val[8*int'(pick) +: 8];
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (eng_busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q >= 20'(START_CYC)) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      WAIT_DONE: begin
        if (!eng_busy) begin
          state_d = REPORT;
          err_d   = 1'b0;
        end else if (cnt_q >= 20'(TIMEOUT_CYC)) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      RECOVER: begin
        // Entered with cnt_q=0, so the engine sees exactly RST_CYC low cycles.
        if (cnt_q >= 20'(RST_CYC - 1)) begin
          state_d = REPORT;
          err_d   = 1'b1;
        end
      end
      REPORT: begin
`ifdef DS3502_INIT_EN
        if (init_ph_q) begin
          init_ph_d = 1'b0;
          if (!init_sel_q) begin
            state_d = INIT1;
          end else begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          ptr_d   = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
`else
        ptr_d   = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
`endif
      end
`ifdef DS3502_INIT_EN
      INIT0: begin
        addr_d     = 8'h02;
        val_d      = INIT_CR;
        init_ph_d  = 1'b1;
        init_sel_d = 1'b0;
        state_d    = LOAD;
      end
      INIT1: begin
        addr_d     = 8'h00;
        val_d      = INIT_WR;
        init_ph_d  = 1'b1;
        init_sel_d = 1'b1;
        state_d    = LOAD;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      val_q       <= '0;
      rst_n_q     <= 1'b0;
      init_done_q <= 1'b0;
`ifdef DS3502_INIT_EN
      init_ph_q   <= 1'b0;
      init_sel_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      val_q       <= val_d;
      rst_n_q     <= (state_d != RECOVER);
      init_done_q <= init_done_d;
`ifdef DS3502_INIT_EN
      init_ph_q   <= init_ph_d;
      init_sel_q  <= init_sel_d;
`endif
    end
  end

  always_comb begin
    done = '0;
    if (state_q == REPORT && !in_init) done[grant_q] = 1'b1;
  end

  assign err       = (state_q == REPORT) && !in_init && err_q;
  assign eng_load  = (state_q == LOAD);
  assign eng_addr  = addr_q;
  assign eng_val   = val_q;
  assign eng_rst_n = rst_n_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ds3502_wr_sched.sv
// Bench for ds3502_wr_sched (default build). A behavioural engine raises busy one cycle after
// load for 300 cycles, or hangs (never drops / never raises busy) per batch. Each batch of held
// requests is expanded by a reference model into its round-robin service order; a monitor
// compares every load and done against that queue.
module tb_ds3502_wr_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_addr;
  logic [8*N-1:0] req_val;
  logic [N-1:0]   done;
  logic           err;
  logic           eng_load;
  logic [7:0]     eng_addr;
  logic [7:0]     eng_val;
  logic           eng_busy;
  logic           eng_rst_n;
  logic           init_done;

  ds3502_wr_sched #(
    .N_REQ      (N),
    .TIMEOUT_CYC(1000),
    .START_CYC  (4),
    .RST_CYC    (16),
    .INIT_CR    (8'h80),
    .INIT_WR    (8'h40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_val  (req_val),
    .done     (done),
    .err      (err),
    .eng_load (eng_load),
    .eng_addr (eng_addr),
    .eng_val  (eng_val),
    .eng_busy (eng_busy),
    .eng_rst_n(eng_rst_n),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] v;
    logic       e;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mode     = 0; // 0 normal, 1 busy never drops, 2 busy never rises
  int         ptr_m    = 0;
  int         exp_recs = 0;
  int         recs     = 0;
  logic [7:0] addr_a[N];
  logic [7:0] val_a[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural engine.
  int eng_cnt;
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (eng_load && mode != 2) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 0;
    end else if (eng_busy && mode != 1) begin
      if (eng_cnt == 299) eng_busy <= 1'b0;
      else eng_cnt <= eng_cnt + 1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (eng_load) begin
        if (exp_q.size() == 0) chk("load_unexpected", 32'(eng_load), 32'd0);
        else begin
          chk("load_addr", 32'(eng_addr), 32'(exp_q[0].a));
          chk("load_val", 32'(eng_val), 32'(exp_q[0].v));
        end
      end
      if (done != '0 || err) begin
        if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else begin
          exp_t e;
          logic [N-1:0] ed;
          e  = exp_q.pop_front();
          ed = '0;
          ed[e.idx] = 1'b1;
          chk("done_vec", 32'(done), 32'(ed));
          chk("done_err", 32'(err), 32'(e.e));
          chk("addr_held", 32'(eng_addr), 32'(e.a));
          chk("val_held", 32'(eng_val), 32'(e.v));
        end
      end
    end
  end

  // Recovery pulse width monitor; ignores the low phase left over from block reset.
  int low_cnt  = 0;
  bit tracking = 1'b0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      tracking = 1'b0;
      low_cnt  = 0;
    end else if (eng_rst_n) begin
      if (tracking && low_cnt > 0) begin
        chk("recover_width", 32'(low_cnt), 32'd16);
        recs++;
      end
      tracking = 1'b1;
      low_cnt  = 0;
    end else if (tracking) begin
      low_cnt++;
    end
  end

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_addr[8*i +: 8] = addr_a[i];
      req_val[8*i +: 8]  = val_a[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    exp_q.delete();
    ptr_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_load", 32'(eng_load), 32'd0);
    chk("rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_eng_rst_n", 32'(eng_rst_n), 32'd1);
    chk("post_rst_init_done", 32'(init_done), 32'd1);
  endtask

  // Holds each requester of v until its done; the model expands v into the rotating order.
  task automatic run_batch(input logic [N-1:0] v, input int md, input bit rnd);
    int n, served, guard, last;
    @(negedge clk);
    mode = md;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        addr_a[i] = 8'($urandom);
        val_a[i]  = 8'($urandom);
      end
    end
    pack();
    n    = 0;
    last = ptr_m;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (v[j]) begin
        exp_q.push_back('{idx: j, a: addr_a[j], v: val_a[j], e: (md != 0)});
        if (md != 0) exp_recs++;
        last = j;
        n++;
      end
    end
    if (n > 0) ptr_m = (last + 1) % N;
    req    = v;
    served = 0;
    guard  = 0;
    while (served < n && guard < n * 1500 + 50) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          served++;
          req[i] = 1'b0;
        end
      end
      guard++;
    end
    if (served < n) begin
      chk("batch_timeout", 32'(served), 32'(n));
      do_reset();
    end else begin
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b0;
    req      = '0;
    req_addr = '0;
    req_val  = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_load", 32'(eng_load), 32'd0);
    chk("reset_addr", 32'(eng_addr), 32'd0);
    chk("reset_val", 32'(eng_val), 32'd0);
    chk("reset_eng_rst_n", 32'(eng_rst_n), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_done_high", 32'(init_done), 32'd1);
    chk("eng_rst_n_high", 32'(eng_rst_n), 32'd1);

    // All four held from ptr=0, then single requester with fixed slice.
    run_batch(4'b1111, 0, 1'b1);
    addr_a[0] = 8'h00;
    val_a[0]  = 8'h7F;
    run_batch(4'b0001, 0, 1'b0);
    // ptr ends at 2, so 0011 must wrap to 0 first.
    run_batch(4'b0010, 0, 1'b1);
    run_batch(4'b0011, 0, 1'b1);
    // Hung engine, missing start, then a normal request.
    run_batch(4'b0100, 1, 1'b1);
    run_batch(4'b1000, 2, 1'b1);
    run_batch(4'b0001, 0, 1'b1);

    // Reset mid-transaction: the pending transfer is dropped without done.
    @(negedge clk);
    mode = 0;
    exp_q.push_back('{idx: 2, a: addr_a[2], v: val_a[2], e: 1'b0});
    req = 4'b0100;
    repeat (40) @(negedge clk);
    do_reset();
    run_batch(4'b1010, 0, 1'b1);

    for (int b = 0; b < 10; b++) begin
      int md;
      md = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_batch(4'($urandom_range(1, 15)), md, 1'b1);
    end

    chk("recover_count", 32'(recs), 32'(exp_recs));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
